// File: rtl/exp_2.sv
// Binary-to-one-hot decoder with a valid/ready output beat and optional sweep mode.
// Define EXP2_SWEEP_EN to add the sweep input, which emits 1<<0 .. 1<<E as a burst.
module exp_2 #(
  parameter int EXP_W = 3
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic [EXP_W-1:0]      exponent,
`ifdef EXP2_SWEEP_EN
  input  logic                  sweep,
`endif
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [(2**EXP_W)-1:0] onehot,
  output logic                  out_last
);
  localparam int OUT_W = 2**EXP_W;

  localparam logic [1:0] IDLE  = 2'd0;
  localparam logic [1:0] HOLD  = 2'd1;
`ifdef EXP2_SWEEP_EN
  localparam logic [1:0] SWEEP = 2'd2;
`endif

  logic [1:0]       state;
  logic [EXP_W-1:0] sel;
  logic             accept;
  logic             xfer;

  assign in_ready  = !rst && ((state == IDLE) || ((state == HOLD) && out_ready));
  assign out_valid = (state != IDLE);
  assign out_last  = (state == HOLD);
  assign accept    = in_valid && in_ready;
  assign xfer      = out_valid && out_ready;

`ifdef EXP2_SWEEP_EN
  logic [EXP_W-1:0] idx;
  logic [EXP_W-1:0] cap;

  assign sel = idx;

  // idx stops at cap (<= OUT_W-1), so the counter cannot wrap.
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
      idx   <= '0;
      cap   <= '0;
    end else if (accept) begin
      cap <= exponent;
      if (sweep && (exponent != '0)) begin
        state <= SWEEP;
        idx   <= '0;
      end else begin
        state <= HOLD;
        idx   <= exponent;
      end
    end else if (xfer) begin
      if (state == SWEEP) begin
        idx <= idx + 1'b1;
        if ((idx + 1'b1) == cap) state <= HOLD;
      end else begin
        state <= IDLE;
        idx   <= '0;
      end
    end
  end
`else
  logic [EXP_W-1:0] exp_q;

  assign sel = exp_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
      exp_q <= '0;
    end else if (accept) begin
      state <= HOLD;
      exp_q <= exponent;
    end else if (xfer) begin
      state <= IDLE;
      exp_q <= '0;
    end
  end
`endif

  // Gating with out_valid keeps the word all-zero between beats.
  for (genvar i = 0; i < OUT_W; i++) begin : g_dec
    localparam logic [EXP_W-1:0] BIT_IDX = i;
    assign onehot[i] = out_valid && (sel == BIT_IDX);
  end

endmodule

// File: doc/exp_2.md
EXP_2 -- requirements
Module: exp_2

Interface
REQ-001 The block SHALL have parameter EXP_W, default 3, giving the exponent width; OUT_W = 2**EXP_W is derived and SHALL NOT be overridable.
REQ-002 The block SHALL have port clk, input, 1 bit: the single clock; all state updates on its rising edge.
REQ-003 The block SHALL have port rst, input, 1 bit: reset, synchronous and active-high.
REQ-004 The block SHALL have port in_valid, input, 1 bit: exponent request valid.
REQ-005 The block SHALL have port in_ready, output, 1 bit: block can accept a request this cycle.
REQ-006 The block SHALL have port exponent, input, EXP_W bits: binary index to decode into a one-hot word.
REQ-007 The block SHALL have port sweep, input, 1 bit, present only with EXP2_SWEEP_EN: request a sweep run instead of a single beat.
REQ-008 The block SHALL have port out_valid, output, 1 bit: onehot/out_last valid.
REQ-009 The block SHALL have port out_ready, input, 1 bit: downstream accepts the beat.
REQ-010 The block SHALL have port onehot, output, OUT_W bits: the decoded word, 1 << index.
REQ-011 The block SHALL have port out_last, output, 1 bit: final beat of the current request.

Function
REQ-012 The block SHALL use FSM states IDLE (no beat pending), HOLD (final beat presented) and SWEEP (non-final sweep beat presented).
REQ-013 A request SHALL be accepted when in_valid & in_ready at a clk edge.
REQ-014 in_ready SHALL be a combinational output equal to !rst & (IDLE | (HOLD & out_ready)), allowing back-to-back requests with zero bubble.
REQ-015 A beat SHALL be transferred when out_valid & out_ready at a clk edge.
REQ-016 On an accepted single request, onehot SHALL become 1 << exponent and out_valid and out_last SHALL become 1 at the next edge, with state HOLD; latency is 1 cycle.
REQ-017 In HOLD, onehot, out_last and out_valid SHALL stay stable until transferred.
REQ-018 In HOLD, a transfer without a new accept SHALL return the FSM to IDLE with out_valid=0 and onehot=0.
REQ-019 In HOLD, a transfer with a simultaneous accept SHALL load the new request in the same edge.
REQ-020 On an accepted sweep request with exponent E, the block SHALL capture E and emit beats 1<<0, 1<<1, ..., 1<<E in order, one per transfer.
REQ-021 In a sweep, out_last SHALL be 1 only on beat 1<<E; state is SWEEP while index<E and HOLD on the last beat.
REQ-022 A sweep with E=0 SHALL emit a single beat 0x01 with out_last=1 and be handled exactly like a single request.
REQ-023 onehot SHALL always have exactly one bit set while out_valid=1 and SHALL be all-zero while out_valid=0.
REQ-024 The index counter SHALL be EXP_W bits and SHALL never wrap: the sweep terminates at E, including at E = OUT_W-1.
REQ-025 exponent and sweep SHALL be ignored when no accept occurs.

Reset
REQ-026 While rst=1 at an edge, the block SHALL enter IDLE with out_valid=0, onehot=0, out_last=0, and the index and captured exponent cleared.
REQ-027 in_ready SHALL be 0 during any cycle with rst=1.
REQ-028 A reset asserted mid-sweep or mid-HOLD SHALL abandon the request with no further beats.
REQ-029 The first request SHALL be accepted in the cycle after rst deasserts.

Configuration
REQ-030 With macro EXP2_SWEEP_EN defined, the sweep port and SWEEP state SHALL exist as specified.
REQ-031 Without EXP2_SWEEP_EN, the sweep port, SWEEP state and index counter SHALL be absent, every request SHALL be single-beat, and out_last SHALL equal out_valid.

Verification
REQ-032 Single request: exponent=1 accepted, out_ready=1 -> next cycle onehot=8'b00000010, out_valid=1, out_last=1, then IDLE.
REQ-033 Backpressure: exponent=6, out_ready=0 for 3 cycles -> onehot=8'b01000000 held stable with in_ready=0 for 3 cycles; transferred on the cycle out_ready rises.
REQ-034 Back-to-back: in_valid held with exponents 0,7,3, out_ready=1 -> onehot 0x01, 0x80, 0x08 on consecutive cycles, with in_ready=1 each cycle.
REQ-035 Sweep (EXP2_SWEEP_EN): sweep=1, exponent=3, out_ready=1 -> beats 0x01, 0x02, 0x04, 0x08 on consecutive cycles; out_last=1 only on 0x08; sweep=1, exponent=0 -> a single beat 0x01 with out_last=1.
REQ-036 Reset mid-sweep: sweep=1, exponent=7, rst=1 after beat 0x04 -> next cycle out_valid=0, onehot=0, in_ready=0 while rst=1; a later exponent=2 request yields 0x04 with out_last=1.
